// File: rtl/sequencer_pkg.sv
// Shared types and opcode constants for the RV32I multi-cycle sequencer.
// Only the nine base RV32I opcode groups are accepted; anything else traps.
package sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_MEM       = 3'd4,
    ST_WRITEBACK = 3'd5,
    ST_TRAP      = 3'd6
  } state_t;

  localparam logic [6:0] OPC_OPPI   = 7'b0010011;
  localparam logic [6:0] OPC_OPPR   = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  function automatic logic is_valid_opcode(input logic [6:0] opcode);
    logic valid;
    case (opcode)
      OPC_OPPI, OPC_OPPR, OPC_LUI, OPC_AUIPC, OPC_JAL,
      OPC_JALR, OPC_BRANCH, OPC_LOAD, OPC_STORE: valid = 1'b1;
      default:                                    valid = 1'b0;
    endcase
    return valid;
  endfunction

endpackage

// File: rtl/sequencer_r32i_retire_counter.sv
// Retired-instruction counter: synchronous increment, asynchronous clear,
// wraps silently at 2^dataW.
module retire_counter #(
  parameter int dataW = 32
) (
  input  logic             clk,
  input  logic             nClear,
  input  logic             incEn,
  output logic [dataW-1:0] count
);

  logic [dataW-1:0] countQ;

  // Count register; holding its own value keeps the flop load path explicit.
  always_ff @(posedge clk or negedge nClear) begin
    if (!nClear) begin
      countQ <= {dataW{1'b0}};
    end else if (incEn) begin
      countQ <= countQ + {{(dataW-1){1'b0}}, 1'b1};
    end else begin
      countQ <= countQ;
    end
  end

  assign count = countQ;

endmodule

// File: rtl/sequencer_r32i.sv
// Multi-cycle control FSM for the RV32I core: fetch, decode, execute,
// data-memory access and writeback, plus retire counter and illegal-opcode trap.
module sequencer_r32i
  import sequencer_pkg::*;
#(
  parameter int dataW = 32
) (
  input  logic             clk,
  input  logic             nReset,
  input  logic             Run,
  output logic             InsReq,
  input  logic             InsAck,
  output logic             IRLoad,
  input  logic [6:0]       Opcode,
  input  logic             RegWriteControl,
  input  logic             LinkAddrWrite,
  input  logic             TestBranch,
  input  logic             AlwaysBranch,
  input  logic             RAMWriteControl,
  input  logic             RAMRegRead,
  input  logic             BranchTaken,
  output logic             MemReq,
  output logic             MemWrite,
  input  logic             MemAck,
  output logic             RegWriteEn,
  output logic             PCUpdate,
  output logic             PCSelBranch,
  output logic             Trap,
  output logic [dataW-1:0] RetireCount,
  output logic [2:0]       StateOut
);

  state_t stateQ;
  logic   insReqQ;
  logic   memReqQ;
  logic   memWriteQ;
  logic   trapQ;
  logic   takenQ;
  logic   wbActive;

  // Link writes are already folded into RegWriteControl by the decoder.
  logic   unusedLinkAddrWrite;
  assign unusedLinkAddrWrite = LinkAddrWrite;

  // Main sequencer: state plus the handshake/trap outputs, registered so
  // that reset drops the requests asynchronously.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      stateQ    <= ST_IDLE;
      insReqQ   <= 1'b0;
      memReqQ   <= 1'b0;
      memWriteQ <= 1'b0;
      trapQ     <= 1'b0;
      takenQ    <= 1'b0;
    end else begin
      case (stateQ)
        ST_IDLE: begin
          if (Run) begin
            stateQ  <= ST_FETCH;
            insReqQ <= 1'b1;
          end else begin
            stateQ  <= ST_IDLE;
          end
        end
        ST_FETCH: begin
          if (InsAck) begin
            stateQ  <= ST_DECODE;
            insReqQ <= 1'b0;
          end else begin
            stateQ  <= ST_FETCH;
          end
        end
        ST_DECODE: begin
          if (is_valid_opcode(Opcode)) begin
            stateQ <= ST_EXECUTE;
          end else begin
            stateQ <= ST_TRAP;
            trapQ  <= 1'b1;
          end
        end
        ST_EXECUTE: begin
          takenQ <= AlwaysBranch | (TestBranch & BranchTaken);
          if (RAMRegRead) begin
            stateQ    <= ST_MEM;
            memReqQ   <= 1'b1;
            memWriteQ <= RAMWriteControl;
          end else begin
            stateQ    <= ST_WRITEBACK;
          end
        end
        ST_MEM: begin
          if (MemAck) begin
            stateQ    <= ST_WRITEBACK;
            memReqQ   <= 1'b0;
            memWriteQ <= 1'b0;
          end else begin
            stateQ    <= ST_MEM;
          end
        end
        ST_WRITEBACK: begin
          // Run is only honoured here and in IDLE, so an instruction always completes.
          if (Run) begin
            stateQ  <= ST_FETCH;
            insReqQ <= 1'b1;
          end else begin
            stateQ  <= ST_IDLE;
          end
        end
        ST_TRAP: begin
          stateQ <= ST_TRAP;
        end
        default: begin
          stateQ    <= ST_IDLE;
          insReqQ   <= 1'b0;
          memReqQ   <= 1'b0;
          memWriteQ <= 1'b0;
          trapQ     <= 1'b0;
          takenQ    <= 1'b0;
        end
      endcase
    end
  end

  assign wbActive    = (stateQ == ST_WRITEBACK);
  assign InsReq      = insReqQ;
  assign IRLoad      = InsAck & (stateQ == ST_FETCH);
  assign MemReq      = memReqQ;
  assign MemWrite    = memWriteQ;
  assign RegWriteEn  = wbActive & RegWriteControl;
  assign PCUpdate    = wbActive;
  assign PCSelBranch = wbActive & takenQ;
  assign Trap        = trapQ;
  assign StateOut    = stateQ;

  retire_counter #(
    .dataW (dataW)
  ) uRetire (
    .clk    (clk),
    .nClear (nReset),
    .incEn  (wbActive),
    .count  (RetireCount)
  );

endmodule

// File: doc/sequencer_r32i.md
# sequencer_r32i

Multi-cycle control FSM for the RV32I core. Sequences instruction fetch, the decode/execute datapath, data-RAM access and register/PC writeback, using the per-instruction control flags produced by the RV32I decoder. Sits between the instruction/data memory handshakes and the register file, PC and ALU enables. Also provides a retired-instruction counter and a sticky trap on illegal opcodes.

## Interface
Parameters:
- dataW, 32, datapath width; sets the RetireCount width.

Ports:
- clk  in  1  core clock; all state changes on its rising edge.
- nReset  in  1  asynchronous, active-low reset.
- Run  in  1  high = execute; sampled only at instruction boundaries.
- InsReq  out  1  instruction-fetch request.
- InsAck  in  1  instruction word valid this cycle.
- IRLoad  out  1  one-cycle pulse that latches the fetched word into the instruction register.
- Opcode  in  7  rawIns[6:0] from the instruction register.
- RegWriteControl, LinkAddrWrite, TestBranch, AlwaysBranch, RAMWriteControl, RAMRegRead  in  1 each  decoder flags.
- BranchTaken  in  1  conditional-generator result.
- MemReq  out  1  data-RAM request.
- MemWrite  out  1  qualifies MemReq: 1 = store, 0 = load.
- MemAck  in  1  data-RAM access complete.
- RegWriteEn  out  1  register-file write strobe.
- PCUpdate  out  1  PC load strobe.
- PCSelBranch  out  1  with PCUpdate: 1 = branch target, 0 = PC+4.
- Trap  out  1  sticky illegal-opcode flag.
- RetireCount  out  dataW  count of completed instructions.
- StateOut  out  3  current FSM state encoding, for debug.

## Operation
- States, with encodings: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEM=4, WRITEBACK=5, TRAP=6.
- IDLE: all strobes low. Go to FETCH when Run=1.
- FETCH: InsReq=1 until InsAck. In the InsAck cycle, IRLoad=1 and next state is DECODE.
- DECODE: one cycle. If Opcode is not one of OPPI, OPPR, LUI, AUIPC, JAL, JALR, BRANCH, LOAD or STORE, go to TRAP. Otherwise go to EXECUTE.
- EXECUTE: one cycle. Register takenQ = AlwaysBranch | (TestBranch & BranchTaken). Next state is MEM if RAMRegRead=1, otherwise WRITEBACK.
- MEM: MemReq=1 and MemWrite=RAMWriteControl, both held until MemAck. Go to WRITEBACK on the MemAck cycle.
- WRITEBACK: one cycle.
  - RegWriteEn=RegWriteControl (this covers the LinkAddrWrite cases).
  - PCUpdate=1 and PCSelBranch=takenQ.
  - RetireCount increments by 1.
  - Next state is FETCH if Run=1, otherwise IDLE.
- TRAP: Trap=1 and all strobes low. Only nReset leaves TRAP. RetireCount does not increment.
- Flag inputs are read only in DECODE, EXECUTE, MEM and WRITEBACK. InsAck outside FETCH and MemAck outside MEM are ignored.
- Run falling mid-instruction has no effect until WRITEBACK; the current instruction always completes.
- RetireCount wraps from 2^dataW−1 to 0 with no flag.

## Timing
- Reset (asynchronous assert): state=IDLE. InsReq, IRLoad, MemReq, MemWrite, RegWriteEn, PCUpdate, PCSelBranch and Trap are all 0. RetireCount=0, StateOut=0.
- Reset release: the first state change occurs at the first rising clk edge with nReset=1.
- Reset asserted mid-FETCH or mid-MEM drops InsReq/MemReq immediately, without waiting for a clock edge. An ack arriving later is ignored.
- All outputs are Moore (a function of registered state) except:
  - IRLoad, which is InsAck & FETCH;
  - RegWriteEn, PCUpdate and PCSelBranch, which are decoded from the WRITEBACK state and registered takenQ.
- Minimum latency with a same-cycle InsAck:
  - ALU, LUI, AUIPC, JAL, JALR and branch instructions: 4 cycles (FETCH→DECODE→EXECUTE→WRITEBACK).
  - Load/store with a same-cycle MemAck: 5 cycles.
  - Each extra wait cycle adds 1.
- Back-to-back instructions: FETCH is entered on the cycle immediately after WRITEBACK, with no bubble.

## Structure
- Package sequencer_pkg contains:
  - the state_t enum (3-bit, with the encodings above);
  - a function is_valid_opcode(logic [6:0]) built from the shared opcode defines.
- One sub-module, retire_counter: a dataW-bit counter with synchronous increment enable, asynchronous active-low clear and natural wrap.
- The FSM next-state logic and the output decode stay in sequencer_r32i.

## Test plan
- Reset, then Run=1, one ADDI (0x00500093), InsAck the same cycle → StateOut follows 1,2,3,5,1. RegWriteEn=1 and PCUpdate=1 with PCSelBranch=0 in the WRITEBACK cycle. RetireCount=1.
- LW (0x0000A103), MemAck delayed 3 cycles → MemReq=1 and MemWrite=0 for 4 cycles. RegWriteEn asserts in the cycle after MemAck. Total 8 cycles.
- SW (0x0020A023) → MemWrite=1 throughout MEM, RegWriteEn=0 in WRITEBACK. BEQ (0x00208463) with BranchTaken=1 in EXECUTE → PCSelBranch=1, RegWriteEn=0. Same BEQ with BranchTaken=0 → PCSelBranch=0.
- Opcode 0x7F → TRAP at DECODE+1. Trap stays 1, no further InsReq, RetireCount unchanged. Pulsing nReset clears Trap and returns StateOut=0.
- nReset asserted mid-MEM (MemReq=1) → MemReq=0 in the same cycle without a clk edge. A subsequent stray MemAck while in IDLE changes no state.
- Run dropped during EXECUTE → the instruction completes, then IDLE. Preload the counter to 0xFFFFFFFF through a force, retire one instruction → RetireCount=0.
